// File: rtl/aleph_result_packer.sv
// aleph_result_packer: buffers mining results (nonce + hash) in a small
// first-word-fall-through FIFO as packed 512-bit records. It launches batched
// write transactions through the write master's control port, streams the
// records over a valid/ready interface, and then waits for the write response.
// Each batch targets the next 4 KiB slot of a ring in host memory.
//
// Optional feature: define ALEPH_PACKER_TIMESTAMP_EN to compile in a
// free-running 32-bit cycle counter whose value at acceptance is stored in
// record bits [511:480]. Without it those bits hold 32'hA1E9_0000.

module aleph_result_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BATCH  = 8,
  parameter int NUM_SLOTS  = 4
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         enable_i,
  input  logic [63:0]  base_addr_i,
  input  logic         res_vld_i,
  input  logic [191:0] res_nonce_i,
  input  logic [255:0] res_hash_i,
  output logic         ctrl_start_o,
  output logic [63:0]  ctrl_addr_offset_o,
  output logic [63:0]  ctrl_xfer_size_o,
  output logic         vld_o,
  input  logic         rdy_i,
  output logic [511:0] data_o,
  input  logic         bvld_i,
  output logic         busy_o,
  output logic [15:0]  drop_cnt_o,
  output logic [31:0]  batch_cnt_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int BW = 7;  // beat counter, MAX_BATCH <= 64

  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_BATCH_C = CW'(MAX_BATCH);
  localparam logic [SW-1:0] LAST_SLOT_C = SW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT_B = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [511:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     seq_q, seq_d;
  logic [15:0]     drop_q, drop_d;
  logic [31:0]     batch_q, batch_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     size_q, size_d;

  logic            pop_s;
  logic            push_s;
  logic [CW-1:0]   batch_n_s;
  logic [31:0]     stamp_s;
  logic [511:0]    rec_s;
  logic            unused_base_s;

  // Low address bits are forced to zero, so they are deliberately not used.
  assign unused_base_s = ^base_addr_i[11:0];

`ifdef ALEPH_PACKER_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;

  // Free-running cycle counter used to timestamp accepted results.
  always_comb begin
    ts_d = ts_q + 32'd1;
  end

  // Timestamp counter register.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign stamp_s = ts_q;
`else
  assign stamp_s = 32'hA1E9_0000;
`endif

  // Record is assembled at acceptance time so the FIFO stores it whole.
  assign rec_s = {stamp_s, seq_q, res_hash_i, res_nonce_i};

  // Pop whenever a streamed beat is handshaken; push if space exists or a
  // pop frees an entry in the same cycle.
  assign pop_s  = (state_q == ST_STREAM) && rdy_i;
  assign push_s = res_vld_i && ((count_q != DEPTH_C) || pop_s);

  // Batch size is the smaller of current occupancy and the batch limit.
  assign batch_n_s = (count_q > MAX_BATCH_C) ? MAX_BATCH_C : count_q;

  // FIFO pointers, occupancy, sequence numbering and drop accounting.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      seq_d    = seq_q + 32'd1;
    end else if (res_vld_i && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end else begin
      drop_d = drop_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Batch state machine: next state, latched transaction parameters, slot.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    size_d  = size_q;
    slot_d  = slot_q;
    batch_d = batch_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (count_q != {CW{1'b0}})) begin
          state_d = ST_START;
          beats_d = BW'(batch_n_s);
          size_d  = 64'({batch_n_s, 6'd0});
          addr_d  = {base_addr_i[63:12] + 52'(slot_q), 12'h000};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (rdy_i) begin
          beats_d = beats_q - BW'(1);
          if (beats_q == BW'(1)) begin
            state_d = ST_WAIT_B;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT_B: begin
        if (bvld_i) begin
          state_d = ST_IDLE;
          batch_d = batch_q + 32'd1;
          if (slot_q == LAST_SLOT_C) begin
            slot_d = {SW{1'b0}};
          end else begin
            slot_d = slot_q + SW'(1);
          end
        end else begin
          state_d = ST_WAIT_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and counter registers; reset clears everything immediately.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      seq_q    <= 32'd0;
      drop_q   <= 16'd0;
      batch_q  <= 32'd0;
      slot_q   <= {SW{1'b0}};
      beats_q  <= {BW{1'b0}};
      addr_q   <= 64'd0;
      size_q   <= 64'd0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      batch_q  <= batch_d;
      slot_q   <= slot_d;
      beats_q  <= beats_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
    end
  end

  // Record storage; contents are only observed through valid FIFO entries.
  always_ff @(posedge aclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= rec_s;
    end
  end

  assign ctrl_start_o       = (state_q == ST_START);
  assign vld_o              = (state_q == ST_STREAM);
  assign busy_o             = (state_q != ST_IDLE);
  assign data_o             = (state_q == ST_STREAM) ? mem_q[rd_ptr_q] : {512{1'b0}};
  assign ctrl_addr_offset_o = addr_q;
  assign ctrl_xfer_size_o   = size_q;
  assign drop_cnt_o         = drop_q;
  assign batch_cnt_o        = batch_q;

endmodule
